// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - CSR addresses, cause codes, mstatus fields and FSM states for trap_ctrl
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [3:0] CAUSE_ECALL_M   = 4'd11;
  localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;
  localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;
  localparam int MIE_MEIE       = 11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEPC    = 3'd1,
    S_MCAUSE  = 3'd2,
    S_MSTATUS = 3'd3,
    S_MRET    = 3'd4,
    S_JUMP    = 3'd5
  } trap_state_e;

endpackage

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap sequencer: mepc/mcause/mstatus writes, then one-cycle redirect
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  irq_ext_i,
  input  logic                  irq_timer_i,
  input  logic                  inst_ecall_i,
  input  logic                  inst_mret_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] mstatus_i,
  input  logic [ADDR_WIDTH-1:0] mie_i,
  input  logic [ADDR_WIDTH-1:0] mtvec_i,
  input  logic [ADDR_WIDTH-1:0] mepc_i,
  output logic                  stallreq_o,
  output logic                  csr_we_o,
  output logic [11:0]           csr_waddr_o,
  output logic [ADDR_WIDTH-1:0] csr_wdata_o,
  output logic                  int_en_o,
  output logic [ADDR_WIDTH-1:0] isr_pc_o
);

  trap_state_e           state;
  logic [ADDR_WIDTH-1:0] cause_q;
  logic [ADDR_WIDTH-1:0] trap_mstatus;
  logic [ADDR_WIDTH-1:0] mret_mstatus;
  logic                  ext_take;
  logic                  timer_take;

  function automatic logic [ADDR_WIDTH-1:0] mk_cause(input logic irq, input logic [3:0] code);
    logic [ADDR_WIDTH-1:0] c;
    c = '0;
    c[ADDR_WIDTH-1] = irq;
    c[3:0] = code;
    return c;
  endfunction

  assign ext_take   = mstatus_i[MSTATUS_MIE] & mie_i[MIE_MEIE] & irq_ext_i;
  assign timer_take = mstatus_i[MSTATUS_MIE] & mie_i[MIE_MTIE] & irq_timer_i;

  always_comb begin
    trap_mstatus = mstatus_i;
    trap_mstatus[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
    trap_mstatus[MSTATUS_MIE] = 1'b0;
    trap_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mret_mstatus = mstatus_i;
    mret_mstatus[MSTATUS_MIE] = mstatus_i[MSTATUS_MPIE];
    mret_mstatus[MSTATUS_MPIE] = 1'b1;
  end

  // Outputs are registered on the transition into each state, so each state's
  // write or redirect is visible during the cycle that state is occupied.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cause_q     <= '0;
      stallreq_o  <= 1'b0;
      csr_we_o    <= 1'b0;
      csr_waddr_o <= '0;
      csr_wdata_o <= '0;
      int_en_o    <= 1'b0;
      isr_pc_o    <= '0;
    end else begin
      stallreq_o  <= 1'b1;
      csr_we_o    <= 1'b0;
      csr_waddr_o <= '0;
      csr_wdata_o <= '0;
      int_en_o    <= 1'b0;
      isr_pc_o    <= '0;
      case (state)
        S_IDLE: begin
          if (inst_mret_i) begin
            state       <= S_MRET;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CSR_MSTATUS;
            csr_wdata_o <= mret_mstatus;
          end else if (inst_ecall_i || ext_take || timer_take) begin
            state       <= S_MEPC;
            cause_q     <= inst_ecall_i ? mk_cause(1'b0, CAUSE_ECALL_M) :
                           ext_take     ? mk_cause(1'b1, CAUSE_IRQ_EXT) :
                                          mk_cause(1'b1, CAUSE_IRQ_TIMER);
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CSR_MEPC;
            csr_wdata_o <= pc_i;
          end else begin
            stallreq_o  <= 1'b0;
          end
        end
        S_MEPC: begin
          state       <= S_MCAUSE;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= CSR_MCAUSE;
          csr_wdata_o <= cause_q;
        end
        S_MCAUSE: begin
          state       <= S_MSTATUS;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= CSR_MSTATUS;
          csr_wdata_o <= trap_mstatus;
        end
        S_MSTATUS: begin
          state    <= S_JUMP;
          int_en_o <= 1'b1;
          isr_pc_o <= {mtvec_i[ADDR_WIDTH-1:2], 2'b00};
        end
        S_MRET: begin
          state    <= S_JUMP;
          int_en_o <= 1'b1;
          isr_pc_o <= mepc_i;
        end
        default: begin
          state      <= S_IDLE;
          stallreq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
